twoof5_serializer: RTL and testbench

TWOOF5_SERIALIZER -- requirements
Module: twoof5_serializer

---
 rtl/twoof5_serializer_pkg.sv | 39 +++
 rtl/twoof5_serializer_codeword.sv | 75 +++++++
 rtl/twoof5_serializer.sv | 114 +++++++++++
 tb/tb_twoof5_serializer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/twoof5_serializer_pkg.sv
// ============================================================================
// Module : SerialTOFEDDefs_2of5 (package)
// Brief  : Shared 2-of-5 codeword definitions: FSM states and encoding table
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package SerialTOFEDDefs_2of5;

    localparam int FBIBBLE_SIZE = 5;

    typedef logic [FBIBBLE_SIZE-1:0] codeword_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam codeword_t INVALID_CODE = '0;

    // 7-4-2-1-0 weighted codes, element 0 is digit 0 (the 7+4 exception).
    localparam logic [0:9][FBIBBLE_SIZE-1:0] ENC_TABLE = {
        5'b11000, 5'b00011, 5'b00101, 5'b00110, 5'b01001,
        5'b01010, 5'b01100, 5'b10001, 5'b10010, 5'b10100
    };

    function automatic codeword_t encode_digit(input logic [3:0] digit);
        codeword_t code;
        if (digit > 4'd9) begin
            code = INVALID_CODE;
        end else begin
            code = ENC_TABLE[digit];
        end
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/twoof5_serializer_codeword.sv
// ============================================================================
// Module : codeword_fifo
// Brief  : Show-ahead FIFO of encoded codewords with registered full/empty
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module codeword_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_n;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_n = count;
        case ({do_push, do_pop})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_n;
            full  <= (count_n == CW'(DEPTH));
            empty <= (count_n == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/twoof5_serializer.sv
// ============================================================================
// Module : twoof5_serializer
// Brief  : BCD digit to serial 2-of-5 codeword stream, MSB first, buffered
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module twoof5_serializer
    import SerialTOFEDDefs_2of5::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] digit_in,
    input  logic       digit_valid,
    output logic       digit_ready,
    output logic       serial_out,
    output logic       bit_valid,
    output logic       frame_start,
    output logic       digit_err
);

    localparam logic [2:0] TOP_BIT = 3'(FBIBBLE_SIZE - 1);

    state_t    state;
    state_t    state_n;
    logic [2:0] bit_cnt;
    logic [2:0] cnt_n;
    codeword_t shift_reg;
    codeword_t shift_n;
    codeword_t fifo_rdata;
    logic      fifo_full;
    logic      fifo_empty;
    logic      push;
    logic      pop;

    assign digit_ready = !fifo_full;
    assign push        = digit_valid && digit_ready;

    codeword_fifo #(
        .WIDTH (FBIBBLE_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wdata   (encode_digit(digit_in)),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_n = state;
        cnt_n   = bit_cnt;
        shift_n = shift_reg;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_rdata;
                    cnt_n   = TOP_BIT;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt != 3'd0) begin
                    shift_n = {shift_reg[FBIBBLE_SIZE-2:0], 1'b0};
                    cnt_n   = bit_cnt - 3'd1;
                end else if (!fifo_empty) begin
                    // Back-to-back reload keeps the bit stream gap-free.
                    pop     = 1'b1;
                    shift_n = fifo_rdata;
                    cnt_n   = TOP_BIT;
                end else begin
                    shift_n = '0;
                    cnt_n   = 3'd0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                shift_n = '0;
                cnt_n   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            shift_reg   <= '0;
            frame_start <= 1'b0;
            digit_err   <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= cnt_n;
            shift_reg   <= shift_n;
            frame_start <= (state_n == SHIFT) && (cnt_n == TOP_BIT);
            digit_err   <= push && (digit_in > 4'd9);
        end
    end

    // shift_reg is cleared on leaving SHIFT, so serial_out idles low.
    assign serial_out = shift_reg[FBIBBLE_SIZE-1];
    assign bit_valid  = (state == SHIFT);

endmodule

`default_nettype wire

// File: tb/tb_twoof5_serializer.sv
// Directed bench for twoof5_serializer: per-scenario tasks with inline checks.
`default_nettype none

module tb_twoof5_serializer;

    logic       clk;
    logic       reset_n;
    logic [3:0] digit_in;
    logic       digit_valid;
    logic       digit_ready;
    logic       serial_out;
    logic       bit_valid;
    logic       frame_start;
    logic       digit_err;

    int n_cmp;
    int n_err;
    int cyc;

    logic bq[$];
    logic fq[$];
    int   cq[$];

    twoof5_serializer #(.FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .serial_out  (serial_out),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .digit_err   (digit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (bit_valid) begin
            bq.push_back(serial_out);
            fq.push_back(frame_start);
            cq.push_back(cyc);
        end
    end

    function automatic int decode(input logic [4:0] w);
        case (w)
            5'b11000: return 0;
            5'b00011: return 1;
            5'b00101: return 2;
            5'b00110: return 3;
            5'b01001: return 4;
            5'b01010: return 5;
            5'b01100: return 6;
            5'b10001: return 7;
            5'b10010: return 8;
            5'b10100: return 9;
            default:  return -1;
        endcase
    endfunction

    task automatic clear_q();
        bq.delete();
        fq.delete();
        cq.delete();
    endtask

    // Holds digit_valid until accepted; leaves valid high on return.
    task automatic push_digit(input logic [3:0] d, output int waits);
        logic ok;
        digit_in    = d;
        digit_valid = 1'b1;
        waits = 0;
        ok = 1'b0;
        while (!ok) begin
            @(negedge clk);
            if (digit_ready) begin
                ok = 1'b1;
            end else begin
                waits++;
                if (waits > 200) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL push_timeout digit=%0d waited=%0d limit=200", d, waits);
                    ok = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        digit_valid = 1'b0;
        digit_in = 4'd0;
        repeat (3) @(negedge clk);
        n_cmp++; if (digit_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got=%b exp=1", digit_ready); end
        n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL rst_bit_valid got=%b exp=0", bit_valid); end
        n_cmp++; if (serial_out !== 1'b0) begin n_err++; $display("FAIL rst_serial got=%b exp=0", serial_out); end
        n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL rst_frame got=%b exp=0", frame_start); end
        n_cmp++; if (digit_err !== 1'b0) begin n_err++; $display("FAIL rst_err got=%b exp=0", digit_err); end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [4:0] exp;
        int w;
        exp = 5'b00110;
        clear_q();
        push_digit(4'd3, w);
        digit_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL single_latency bit_valid got=%b exp=0", bit_valid); end
        n_cmp++; if (digit_err !== 1'b0) begin n_err++; $display("FAIL single_err got=%b exp=0", digit_err); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (serial_out !== exp[4-i] || bit_valid !== 1'b1 || frame_start !== (i == 0))
                begin n_err++; $display("FAIL single_bit%0d got s=%b v=%b f=%b exp s=%b v=1 f=%b", i, serial_out, bit_valid, frame_start, exp[4-i], (i == 0)); end
        end
        @(negedge clk);
        n_cmp++; if (bit_valid !== 1'b0 || serial_out !== 1'b0) begin n_err++; $display("FAIL single_end got v=%b s=%b exp v=0 s=0", bit_valid, serial_out); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [14:0] exp;
        int w;
        exp = 15'b11000_10100_01010;
        clear_q();
        push_digit(4'd0, w);
        push_digit(4'd9, w);
        n_cmp++; if (w !== 0) begin n_err++; $display("FAIL b2b_stall got=%0d exp=0", w); end
        push_digit(4'd5, w);
        digit_valid = 1'b0;
        repeat (25) @(negedge clk);
        n_cmp++; if (bq.size() !== 15) begin n_err++; $display("FAIL b2b_count got=%0d exp=15", bq.size()); end
        if (bq.size() == 15) begin
            for (int i = 0; i < 15; i++) begin
                n_cmp++; if (bq[i] !== exp[14-i] || fq[i] !== (i % 5 == 0) || cq[i] !== cq[0] + i)
                    begin n_err++; $display("FAIL b2b_bit%0d got s=%b f=%b cyc=%0d exp s=%b f=%b cyc=%0d", i, bq[i], fq[i], cq[i], exp[14-i], (i % 5 == 0), cq[0] + i); end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [19:0] exp;
        int w;
        exp = 20'b00011_00101_01001_10001;
        clear_q();
        push_digit(4'd1, w);
        push_digit(4'd2, w);
        push_digit(4'd4, w);
        n_cmp++; if (w !== 0) begin n_err++; $display("FAIL bp_third_wait got=%0d exp=0", w); end
        n_cmp++; if (digit_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_low got=%b exp=0", digit_ready); end
        push_digit(4'd7, w);
        n_cmp++; if (w !== 4) begin n_err++; $display("FAIL bp_fourth_wait got=%0d exp=4", w); end
        digit_valid = 1'b0;
        repeat (30) @(negedge clk);
        n_cmp++; if (bq.size() !== 20) begin n_err++; $display("FAIL bp_count got=%0d exp=20", bq.size()); end
        if (bq.size() == 20) begin
            for (int i = 0; i < 20; i++) begin
                n_cmp++; if (bq[i] !== exp[19-i] || cq[i] !== cq[0] + i)
                    begin n_err++; $display("FAIL bp_bit%0d got s=%b cyc=%0d exp s=%b cyc=%0d", i, bq[i], cq[i], exp[19-i], cq[0] + i); end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_invalid();
        int w;
        clear_q();
        push_digit(4'd12, w);
        digit_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (digit_err !== 1'b1) begin n_err++; $display("FAIL inv_err_pulse got=%b exp=1", digit_err); end
        @(negedge clk);
        n_cmp++; if (digit_err !== 1'b0) begin n_err++; $display("FAIL inv_err_end got=%b exp=0", digit_err); end
        repeat (10) @(negedge clk);
        n_cmp++; if (bq.size() !== 5) begin n_err++; $display("FAIL inv_count got=%0d exp=5", bq.size()); end
        if (bq.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++; if (bq[i] !== 1'b0 || fq[i] !== (i == 0))
                    begin n_err++; $display("FAIL inv_bit%0d got s=%b f=%b exp s=0 f=%b", i, bq[i], fq[i], (i == 0)); end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int w;
        push_digit(4'd8, w);
        push_digit(4'd6, w);
        digit_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_cmp++; if (bit_valid !== 1'b1 || serial_out !== 1'b0) begin n_err++; $display("FAIL rmid_bit2 got v=%b s=%b exp v=1 s=0", bit_valid, serial_out); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (bit_valid !== 1'b0 || serial_out !== 1'b0 || frame_start !== 1'b0 || digit_ready !== 1'b1 || digit_err !== 1'b0)
            begin n_err++; $display("FAIL rmid_async got v=%b s=%b f=%b r=%b e=%b exp 0 0 0 1 0", bit_valid, serial_out, frame_start, digit_ready, digit_err); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        clear_q();
        repeat (20) @(negedge clk);
        n_cmp++; if (bq.size() !== 0) begin n_err++; $display("FAIL rmid_silent got=%0d bits exp=0", bq.size()); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int exp_d[$];
        int w;
        int d;
        int wd;
        logic [4:0] word;
        int ones;
        clear_q();
        for (int k = 0; k < 20; k++) begin
            d = $urandom_range(9, 0);
            exp_d.push_back(d);
            push_digit(4'(d), w);
            digit_valid = 1'b0;
            repeat ($urandom_range(3, 0)) @(posedge clk);
            #1;
        end
        w = 0;
        while (bq.size() < 100 && w < 400) begin
            @(negedge clk);
            w++;
        end
        repeat (5) @(negedge clk);
        n_cmp++; if (bq.size() !== 100) begin n_err++; $display("FAIL rnd_count got=%0d exp=100", bq.size()); end
        if (bq.size() == 100) begin
            for (int k = 0; k < 20; k++) begin
                ones = 0;
                for (int b = 0; b < 5; b++) begin
                    word[4-b] = bq[k*5+b];
                    if (bq[k*5+b]) ones++;
                end
                wd = decode(word);
                n_cmp++; if (wd !== exp_d[k] || ones !== 2 || fq[k*5] !== 1'b1)
                    begin n_err++; $display("FAIL rnd_frame%0d got word=%b dec=%0d ones=%0d f=%b exp dec=%0d ones=2 f=1", k, word, wd, ones, fq[k*5], exp_d[k]); end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_invalid();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
